// File: rtl/axi_dmem_if.sv
// AXI4-Lite channel bundle between the core's MEM stage (master) and axi_dmem (slave).
interface axi_dmem_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_dmem.sv
// Single-port word data memory behind an AXI4-Lite slave: one outstanding read and one
// outstanding write, byte-strobed writes, full-word reads.
// Optional macro AXI_DMEM_DECERR_EN: out-of-range addresses get DECERR instead of aliasing.
module axi_dmem #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input logic        clk,
  input logic        rstn,
  axi_dmem_if.slave  axi
);

  typedef enum logic [1:0] {RIdle, RMem, RData} r_state_e;
  typedef enum logic [1:0] {WAddr, WCommit, WResp} w_state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespDecerr = 2'b11;

  logic [31:0] mem [2**ADDR_WIDTH];

  r_state_e              r_state_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q;
  logic                  rd_err_q;
  logic [31:0]           rd_word_q;

  w_state_e              w_state_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  aw_got_q;
  logic                  w_got_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic                  wr_err_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;

  logic [ADDR_WIDTH-1:0] ar_idx;
  logic [ADDR_WIDTH-1:0] aw_idx;
  logic                  ar_oor;
  logic                  aw_oor;
  logic                  ar_hs;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  aw_have;
  logic                  w_have;
  logic                  w_go_commit;
  logic                  w_release;
  logic                  r_next_idle;
  logic                  arready_d;
  logic                  awready_d;
  logic                  wready_d;
  logic                  mem_we;
  logic                  unused_addr_lo;

  assign ar_idx = axi.araddr[ADDR_WIDTH+1:2];
  assign aw_idx = axi.awaddr[ADDR_WIDTH+1:2];
  assign unused_addr_lo = ^{axi.araddr[1:0], axi.awaddr[1:0]};

`ifdef AXI_DMEM_DECERR_EN
  assign ar_oor = |axi.araddr[31:ADDR_WIDTH+2];
  assign aw_oor = |axi.awaddr[31:ADDR_WIDTH+2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^{axi.araddr[31:ADDR_WIDTH+2], axi.awaddr[31:ADDR_WIDTH+2]};
  assign ar_oor = 1'b0;
  assign aw_oor = 1'b0;
`endif

  assign ar_hs = axi.arvalid && arready_q;
  assign aw_hs = axi.awvalid && awready_q;
  assign w_hs  = axi.wvalid && wready_q;

  // Next-cycle ready values; arready is withheld in the cycle the commit owns the array.
  always_comb begin
    aw_have     = aw_got_q || aw_hs;
    w_have      = w_got_q || w_hs;
    w_go_commit = (w_state_q == WAddr) && aw_have && w_have;
    w_release   = (w_state_q == WResp) && axi.bready;
    r_next_idle = ((r_state_q == RIdle) && !ar_hs) || ((r_state_q == RData) && axi.rready);
    arready_d   = r_next_idle && !w_go_commit;
    awready_d   = ((w_state_q == WAddr) && !w_go_commit && !aw_have) || w_release;
    wready_d    = ((w_state_q == WAddr) && !w_go_commit && !w_have) || w_release;
  end

  // Read FSM: accept AR, one array-latency cycle, then hold R until taken.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state_q <= RIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      rd_err_q  <= 1'b0;
    end else begin
      arready_q <= arready_d;
      unique case (r_state_q)
        RIdle: begin
          if (ar_hs) begin
            rd_err_q  <= ar_oor;
            r_state_q <= RMem;
          end
        end
        RMem: begin
          rdata_q   <= rd_err_q ? 32'h0 : rd_word_q;
          rresp_q   <= rd_err_q ? RespDecerr : RespOkay;
          rvalid_q  <= 1'b1;
          r_state_q <= RData;
        end
        RData: begin
          if (axi.rready) begin
            rvalid_q  <= 1'b0;
            r_state_q <= RIdle;
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  // Array read happens on the AR handshake, a cycle that can never be a commit cycle.
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      rd_word_q <= mem[ar_idx];
    end
  end

  // Write FSM: collect AW and W independently, commit for one cycle, then hold B.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state_q <= WAddr;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      waddr_q   <= '0;
      wr_err_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      unique case (w_state_q)
        WAddr: begin
          if (aw_hs) begin
            aw_got_q <= 1'b1;
            waddr_q  <= aw_idx;
            wr_err_q <= aw_oor;
          end
          if (w_hs) begin
            w_got_q <= 1'b1;
            wdata_q <= axi.wdata;
            wstrb_q <= axi.wstrb;
          end
          if (w_go_commit) begin
            w_state_q <= WCommit;
          end
        end
        WCommit: begin
          bvalid_q  <= 1'b1;
          bresp_q   <= wr_err_q ? RespDecerr : RespOkay;
          w_state_q <= WResp;
        end
        WResp: begin
          if (axi.bready) begin
            bvalid_q  <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            w_state_q <= WAddr;
          end
        end
        default: w_state_q <= WAddr;
      endcase
    end
  end

  assign mem_we = rstn && (w_state_q == WCommit) && !wr_err_q;

  // Byte-lane array write during the commit cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[waddr_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;

endmodule
